// File: rtl/csr_file.sv
// csr_file: machine-mode CSR responder for the cpu core.
// Provides 64-bit mcycle/minstret counters (with read-only user aliases),
// mscratch, an LED output register and a synchronized switch input.
// Optional feature macro: CSR_TIMER_EN adds a timer compare register at
// 0x7C2 and a sticky o_timer_irq; without it o_timer_irq is tied low.
module csr_file #(
    parameter int LED_WIDTH = 8,
    parameter int SW_WIDTH  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clk_ce,
    input  logic [11:0]          i_csr_addr,
    input  logic [31:0]          i_csr_wr_data,
    input  logic                 i_csr_wr,
    input  logic                 i_csr_rd,
    output logic [31:0]          o_csr_rd_data,
    output logic                 o_csr_ill,
    input  logic                 i_retire,
    input  logic [SW_WIDTH-1:0]  i_switch,
    output logic [LED_WIDTH-1:0] o_led,
    output logic                 o_timer_irq
);

    localparam logic [11:0] ADDR_MCYCLE      = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH     = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET    = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH   = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE       = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH      = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET     = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH    = 12'hC82;
    localparam logic [11:0] ADDR_MSCRATCH    = 12'h340;
    localparam logic [11:0] ADDR_LED         = 12'h7C0;
    localparam logic [11:0] ADDR_SWITCH      = 12'h7C1;
`ifdef CSR_TIMER_EN
    localparam logic [11:0] ADDR_TIMER_CMP   = 12'h7C2;
`endif

    logic [63:0]          mcycle_reg, mcycle_next;
    logic [63:0]          minstret_reg, minstret_next;
    logic [31:0]          mscratch_reg;
    logic [LED_WIDTH-1:0] led_reg;
    logic [SW_WIDTH-1:0]  sw_meta_reg, sw_sync_reg;
    logic [31:0]          led_ext, sw_ext, rd_mux;
    logic                 addr_mapped, addr_ro, wr_ok;
`ifdef CSR_TIMER_EN
    logic [31:0]          timer_cmp_reg;
    logic                 timer_irq_reg;
`endif

    // Zero-extend the narrow LED and switch registers to the 32-bit read bus
    genvar gi;
    for (gi = 0; gi < 32; gi++) begin : g_ext
        if (gi < LED_WIDTH) begin : g_led_bit
            assign led_ext[gi] = led_reg[gi];
        end else begin : g_led_zero
            assign led_ext[gi] = 1'b0;
        end
        if (gi < SW_WIDTH) begin : g_sw_bit
            assign sw_ext[gi] = sw_sync_reg[gi];
        end else begin : g_sw_zero
            assign sw_ext[gi] = 1'b0;
        end
    end

    // Address decode: read mux, mapped/read-only classification
    always_comb begin
        rd_mux      = 32'd0;
        addr_mapped = 1'b0;
        addr_ro     = 1'b0;
        case (i_csr_addr)
            ADDR_MCYCLE:    begin addr_mapped = 1'b1; rd_mux = mcycle_reg[31:0]; end
            ADDR_MCYCLEH:   begin addr_mapped = 1'b1; rd_mux = mcycle_reg[63:32]; end
            ADDR_MINSTRET:  begin addr_mapped = 1'b1; rd_mux = minstret_reg[31:0]; end
            ADDR_MINSTRETH: begin addr_mapped = 1'b1; rd_mux = minstret_reg[63:32]; end
            ADDR_CYCLE:     begin addr_mapped = 1'b1; addr_ro = 1'b1; rd_mux = mcycle_reg[31:0]; end
            ADDR_CYCLEH:    begin addr_mapped = 1'b1; addr_ro = 1'b1; rd_mux = mcycle_reg[63:32]; end
            ADDR_INSTRET:   begin addr_mapped = 1'b1; addr_ro = 1'b1; rd_mux = minstret_reg[31:0]; end
            ADDR_INSTRETH:  begin addr_mapped = 1'b1; addr_ro = 1'b1; rd_mux = minstret_reg[63:32]; end
            ADDR_MSCRATCH:  begin addr_mapped = 1'b1; rd_mux = mscratch_reg; end
            ADDR_LED:       begin addr_mapped = 1'b1; rd_mux = led_ext; end
            ADDR_SWITCH:    begin addr_mapped = 1'b1; addr_ro = 1'b1; rd_mux = sw_ext; end
`ifdef CSR_TIMER_EN
            ADDR_TIMER_CMP: begin addr_mapped = 1'b1; rd_mux = timer_cmp_reg; end
`endif
            default:        begin addr_mapped = 1'b0; end
        endcase
    end

    assign o_csr_rd_data = i_csr_rd ? rd_mux : 32'd0;
    assign o_csr_ill     = ((i_csr_rd | i_csr_wr) & ~addr_mapped) | (i_csr_wr & addr_ro);
    // Only legal, enabled writes touch state
    assign wr_ok         = i_csr_wr & i_clk_ce & addr_mapped & ~addr_ro;

    // Counter next values: a half-write replaces that half and suppresses the increment
    always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + {63'd0, i_retire};
        if (wr_ok && i_csr_addr == ADDR_MCYCLE) begin
            mcycle_next = {mcycle_reg[63:32], i_csr_wr_data};
        end else if (wr_ok && i_csr_addr == ADDR_MCYCLEH) begin
            mcycle_next = {i_csr_wr_data, mcycle_reg[31:0]};
        end
        if (wr_ok && i_csr_addr == ADDR_MINSTRET) begin
            minstret_next = {minstret_reg[63:32], i_csr_wr_data};
        end else if (wr_ok && i_csr_addr == ADDR_MINSTRETH) begin
            minstret_next = {i_csr_wr_data, minstret_reg[31:0]};
        end
    end

    // Counter registers advance only on enabled edges
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcycle_reg   <= 64'd0;
            minstret_reg <= 64'd0;
        end else if (i_clk_ce) begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end

    // Scratch and LED registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mscratch_reg <= 32'd0;
            led_reg      <= '0;
        end else if (wr_ok) begin
            if (i_csr_addr == ADDR_MSCRATCH) mscratch_reg <= i_csr_wr_data;
            if (i_csr_addr == ADDR_LED)      led_reg      <= i_csr_wr_data[LED_WIDTH-1:0];
        end
    end

    assign o_led = led_reg;

    // Two-flop switch synchronizer, runs every clock regardless of enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= i_switch;
            sw_sync_reg <= sw_meta_reg;
        end
    end

`ifdef CSR_TIMER_EN
    // Timer compare and sticky interrupt; a compare write clears and beats a match
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_cmp_reg <= 32'd0;
            timer_irq_reg <= 1'b0;
        end else if (i_clk_ce) begin
            if (wr_ok && i_csr_addr == ADDR_TIMER_CMP) begin
                timer_cmp_reg <= i_csr_wr_data;
                timer_irq_reg <= 1'b0;
            end else if (mcycle_reg[31:0] == timer_cmp_reg) begin
                timer_irq_reg <= 1'b1;
            end
        end
    end

    assign o_timer_irq = timer_irq_reg;
`else
    assign o_timer_irq = 1'b0;
`endif

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR responder for the `cpu` core. It answers the core's CSR read and write strobes with cycle and retired-instruction counters, a scratch register, and board I/O registers for LEDs and switches. It sits beside the core in `top` and replaces the tied-off `i_csr_rd_data` and the ad-hoc LED latch.

## Interface
Parameters:
- `LED_WIDTH`, default 8: width of LED output register.
- `SW_WIDTH`, default 2: width of switch input.

Ports:
- `i_clk`  in  1  sole clock. All state updates on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_clk_ce`  in  1  clock enable, shared with the core. State advances only when high.
- `i_csr_addr`  in  12  CSR address from the core.
- `i_csr_wr_data`  in  32  write data.
- `i_csr_wr`  in  1  write strobe.
- `i_csr_rd`  in  1  read strobe.
- `o_csr_rd_data`  out  32  read data.
- `o_csr_ill`  out  1  illegal access flag.
- `i_retire`  in  1  one-cycle pulse per retired instruction.
- `i_switch`  in  SW_WIDTH  asynchronous board switches.
- `o_led`  out  LED_WIDTH  LED register.
- `o_timer_irq`  out  1  timer interrupt, only when `CSR_TIMER_EN` is defined.

## Operation
- Register map. Anything not listed is unmapped.
  - 0xB00/0xB80 `mcycle`/`mcycleh`: read/write.
  - 0xB02/0xB82 `minstret`/`minstreth`: read/write.
  - 0xC00/0xC80 and 0xC02/0xC82: read-only aliases of the two counters.
  - 0x340 `mscratch`: read/write, 32 bits.
  - 0x7C0 LED: read/write. Low `LED_WIDTH` bits are stored; upper bits read 0.
  - 0x7C1 switch: read-only. Synchronized switches, zero-extended.
  - 0x7C2 timer compare: read/write, only when `CSR_TIMER_EN` is defined.
- Counters are 64 bits wide and wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - `mcycle` increments by 1 on every edge where `i_clk_ce` is high.
  - `minstret` increments by 1 on every edge where `i_clk_ce` and `i_retire` are both high.
- Writes commit on the rising edge when `i_csr_wr` and `i_clk_ce` are both high.
- A write to one counter half replaces that half only.
  - On that edge the whole 64-bit counter does not increment. The write wins over the increment.
  - No carry propagates into or out of the written half on that edge.
- Reads are combinational.
  - `o_csr_rd_data` is the addressed register when `i_csr_rd` is high; otherwise 0.
  - Unmapped addresses read 0.
  - Counter reads return the pre-edge value.
- Read and write to the same address in the same cycle: the read returns the old value, and the write commits at the edge.
- `o_csr_ill` is combinational and high when either holds:
  - `i_csr_rd` or `i_csr_wr` is high and the address is unmapped;
  - `i_csr_wr` is high and the address is 0xC00–0xC82 or 0x7C1.
- An illegal write changes no state.
- Switch input passes through a 2-flop synchronizer clocked every `i_clk`, independent of `i_clk_ce`.
- Reset values:
  - All counters, `mscratch`, LED register, synchronizer flops and timer compare are 0.
  - `o_csr_rd_data` is 0 (strobes are low during reset).
  - `o_csr_ill` is 0.
  - `o_led` is 0.
  - `o_timer_irq` is 0.
- Reset has priority over writes and increments, including mid-count.

## Timing
- Read latency: 0 cycles (same-cycle combinational).
- Write: new value is visible on reads 1 cycle after the committing edge.
- `o_led` is registered and updates on the committing edge.
- Switch input: a switch change reaches the 0x7C1 read value 2 `i_clk` edges later.
- With `i_clk_ce` low, strobes are ignored for state. Reads still return data, and `o_csr_ill` still flags.

## Configuration
- `CSR_TIMER_EN` defined:
  - Timer compare register 0x7C2 exists.
  - `o_timer_irq` is registered. It sets on the edge where `i_clk_ce` is high and `mcycle[31:0]` equals compare.
  - It stays set (sticky) until any legal write to 0x7C2. That write clears it on the same edge.
  - Set and clear on the same edge: clear wins.
- `CSR_TIMER_EN` undefined:
  - 0x7C2 is unmapped (reads 0, flags `o_csr_ill`).
  - `o_timer_irq` is driven 0.

## Test plan
- Counter and reset:
  - Reset, then 10 edges with `i_clk_ce`=1 and 3 `i_retire` pulses → read 0xB00 = 10, 0xB02 = 3, 0xC00 = 10.
  - Assert `i_rst` mid-count → all reads 0 next cycle.
- Write priority and carry:
  - Write 0xFFFF_FFFF to 0xB00. Next edge reads 0xFFFF_FFFF.
  - One further edge → `mcycle` = 0x1_0000_0000 (0xB80 reads 1).
  - Write 0x5 to 0xB80 while counting → 0xB80 = 5; low half unchanged on that edge.
- LED and strobes:
  - Write 0x1A5 to 0x7C0 → `o_led` = 0xA5; read returns 0xA5.
  - With `i_clk_ce`=0, write 0x3C → `o_led` stays 0xA5.
- Illegal access:
  - Write to 0xC00 → `o_csr_ill`=1 and counter unaffected.
  - Read 0x123 → data 0, `o_csr_ill`=1.
  - Write 0x1 to 0x7C1 → `o_csr_ill`=1 and no effect.
- Switch sync: drive `i_switch`=2'b10 → read of 0x7C1 is 0 for 2 edges, then 0x2.
- Timer (`CSR_TIMER_EN` defined):
  - Compare 20 from reset → `o_timer_irq` rises on the edge where `mcycle` = 20, stays high.
  - Write 0x100 to 0x7C2 → `o_timer_irq` clears. With the macro undefined, `o_timer_irq` stays 0 throughout.
